// File: rtl/accum_out_s2.sv
// Per-dir product accumulator with a double-buffered, saturating valid/ready drain.
// Accumulators keep collecting the next block while the snapshot in obuf is drained.
module accum_out_s2 #(
    parameter int PROD_W = 16,
    parameter int OUT_W  = 16,
    parameter int LEN    = 36
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        dir,
    input  logic [5:0]        dir_counter,
    input  logic              data_done,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic [1:0]        out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              overrun,
    output logic              idx_err
);

    localparam int ACC_W = PROD_W + $clog2(LEN);
    localparam logic [5:0] LEN_C = 6'(LEN);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic                    overrun_q, overrun_d;
    logic                    idx_err_q, idx_err_d;
    logic signed [ACC_W-1:0] acc_q  [4];
    logic signed [ACC_W-1:0] acc_d  [4];
    logic signed [ACC_W-1:0] obuf_q [4];
    logic signed [ACC_W-1:0] prod_ext;
    logic                    prod_ok;
    logic                    snap;

    assign prod_ext = {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    assign prod_ok  = prod_valid && (dir_counter < LEN_C);

    // Term 0 restarts the sum, so no explicit clear between blocks is needed.
    for (genvar gi = 0; gi < 4; gi++) begin : g_acc
        assign acc_d[gi] = (prod_ok && dir == 2'(gi))
                         ? ((dir_counter == 6'd0) ? prod_ext : acc_q[gi] + prod_ext)
                         : acc_q[gi];
    end

    function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] x);
        if (x > SAT_MAX)      return {1'b0, {(OUT_W-1){1'b1}}};
        else if (x < SAT_MIN) return {1'b1, {(OUT_W-1){1'b0}}};
        else                  return x[OUT_W-1:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap      = 1'b0;
        overrun_d = overrun_q;
        idx_err_d = idx_err_q | (prod_valid && !(dir_counter < LEN_C));
        case (state_q)
            IDLE: begin
                if (data_done) begin
                    snap    = 1'b1;
                    idx_d   = 2'd0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
                        // A block completing exactly on the final beat chains straight in.
                        if (data_done) snap = 1'b1;
                        else           state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                if (data_done && !(out_ready && idx_q == 2'd3)) overrun_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            overrun_q <= 1'b0;
            idx_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i]  <= '0;
                obuf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            idx_err_q <= idx_err_d;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= acc_d[i];
                if (snap) obuf_q[i] <= acc_d[i];
            end
        end
    end

    assign out_valid = (state_q == DRAIN);
    assign out_idx   = out_valid ? idx_q : 2'd0;
    assign out_data  = out_valid ? sat(obuf_q[idx_q]) : '0;
    assign out_last  = out_valid && (idx_q == 2'd3);
    assign overrun   = overrun_q;
    assign idx_err   = idx_err_q;

endmodule

// File: tb/tb_accum_out_s2.sv
// Directed bench for accum_out_s2: stimulus pushes expected beats, a monitor pops and checks them.
module tb_accum_out_s2;

    logic        clk;
    logic        reset_n;
    logic [1:0]  dir;
    logic [5:0]  dir_counter;
    logic        data_done;
    logic [15:0] prod_in;
    logic        prod_valid;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overrun;
    logic        idx_err;

    typedef struct {
        int data;
        int idx;
        int last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    accum_out_s2 dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dir         (dir),
        .dir_counter (dir_counter),
        .data_done   (data_done),
        .prod_in     (prod_in),
        .prod_valid  (prod_valid),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .overrun     (overrun),
        .idx_err     (idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got idx %0d data %0d expected no beat",
                         out_idx, $signed(out_data));
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                $display("beat idx=%0d data=%0d last=%0b (exp idx=%0d data=%0d last=%0d)",
                         out_idx, $signed(out_data), out_last, b.idx, b.data, b.last);
                check("beat_data", int'($signed(out_data)), b.data);
                check("beat_idx", int'(out_idx), b.idx);
                check("beat_last", int'(out_last), b.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v0, input int v1, input int v2, input int v3);
        int vals[4];
        vals = '{v0, v1, v2, v3};
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 36; c++) begin
                prod_valid  = 1'b1;
                dir         = 2'(d);
                dir_counter = 6'(c);
                prod_in     = 16'(vals[d]);
                tick();
            end
        end
        prod_valid = 1'b0;
    endtask

    task automatic push_block(input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) exp_q.push_back('{data: e[i], idx: i, last: (i == 3) ? 1 : 0});
    endtask

    task automatic pulse_done();
        data_done = 1'b1;
        tick();
        data_done = 1'b0;
    endtask

    task automatic wait_empty();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1; dir = 2'd0; dir_counter = 6'd0; data_done = 1'b0;
        prod_in = 16'd0; prod_valid = 1'b0; out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_idx", int'(out_idx), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_idx_err", int'(idx_err), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // 1: all ones -> 36 per dir
        out_ready = 1'b1;
        feed(1, 1, 1, 1);
        push_block(36, 36, 36, 36);
        pulse_done();
        check("t1_latency_valid", int'(out_valid), 1);
        check("t1_latency_idx", int'(out_idx), 0);
        wait_empty();

        // 2: saturation both ways
        feed(5, -7, 1000, -1000);
        push_block(180, -252, 32767, -32768);
        pulse_done();
        wait_empty();

        // 3: stall holds the idx0 word
        out_ready = 1'b0;
        feed(2, 3, 4, 5);
        push_block(72, 108, 144, 180);
        pulse_done();
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_valid", int'(out_valid), 1);
            check("t3_stall_idx", int'(out_idx), 0);
            check("t3_stall_data", int'($signed(out_data)), 72);
            check("t3_stall_last", int'(out_last), 0);
            tick();
        end
        wait_empty();

        // 5: second data_done on the idx3 transfer chains without overrun
        out_ready = 1'b0;
        feed(1, 1, 1, 1);
        push_block(36, 36, 36, 36);
        pulse_done();
        feed(2, 2, 2, 2);
        out_ready = 1'b1;
        repeat (3) tick();
        push_block(72, 72, 72, 72);
        pulse_done();
        check("t5_chain_valid", int'(out_valid), 1);
        check("t5_chain_idx", int'(out_idx), 0);
        check("t5_no_overrun", int'(overrun), 0);
        wait_empty();

        // 4: data_done mid-drain is dropped and flagged
        out_ready = 1'b0;
        feed(1, 2, 3, 4);
        push_block(36, 72, 108, 144);
        pulse_done();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_overrun_before", int'(overrun), 0);
        feed(9, 9, 9, 9);
        pulse_done();
        check("t4_overrun", int'(overrun), 1);
        check("t4_idx_held", int'(out_idx), 1);
        check("t4_data_held", int'($signed(out_data)), 72);
        wait_empty();

        // 6: async reset mid-drain, then out-of-range index
        out_ready = 1'b0;
        feed(1, 1, 1, 1);
        pulse_done();
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_valid", int'(out_valid), 0);
        check("t6_rst_data", int'(out_data), 0);
        check("t6_rst_idx", int'(out_idx), 0);
        check("t6_rst_overrun", int'(overrun), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        feed(1, 1, 1, 1);
        prod_valid = 1'b1; dir = 2'd0; dir_counter = 6'd40; prod_in = 16'd500;
        tick();
        prod_valid = 1'b0;
        check("t6_idx_err", int'(idx_err), 1);
        out_ready = 1'b1;
        push_block(36, 36, 36, 36);
        pulse_done();
        wait_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
